router_input_port: RTL and testbench

Credit-based router input port that receives 20-bit flits from a processor element (or neighbouring router) and returns one credit per flit freed. Buffers up to DEPTH flits, computes the XY output port from each head flit, and holds that port for the rest of the packet. Presents flits to the crossbar/switch allocator through a valid/ready handshake. Sits directly downstream of the PE injection path; its credit output drives the PE's credit input.

---
 rtl/router_input_port_pkg.sv | 51 +++++
 rtl/router_input_port_if.sv | 24 ++
 rtl/router_input_port_flit_fifo.sv | 66 ++++++
 rtl/router_input_port.sv | 94 +++++++++
 tb/tb_router_input_port.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/router_input_port_pkg.sv
// Shared flit format, state and routing definitions
// for the router input port.
package router_input_port_pkg;

    localparam int FLIT_W        = 20;
    localparam int DEFAULT_DEPTH = 4;
    localparam int CNT_W         = 3;

    localparam int TYPE_HI = 19;
    localparam int TYPE_LO = 18;
    localparam int DX_HI   = 17;
    localparam int DX_LO   = 16;
    localparam int DY_HI   = 15;
    localparam int DY_LO   = 14;

    localparam int P_L = 0;
    localparam int P_N = 1;
    localparam int P_S = 2;
    localparam int P_E = 3;
    localparam int P_W = 4;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_HEAD,
        ST_BODY
    } state_e;

    // Dimension-ordered XY: resolve X first, then Y, else local.
    function automatic logic [4:0] xy_route(
        input logic [1:0] dx,
        input logic [1:0] dy,
        input logic [1:0] x_id,
        input logic [1:0] y_id
    );
        logic [4:0] r;
        r = '0;
        if (dx > x_id)      r[P_E] = 1'b1;
        else if (dx < x_id) r[P_W] = 1'b1;
        else if (dy > y_id) r[P_N] = 1'b1;
        else if (dy < y_id) r[P_S] = 1'b1;
        else                r[P_L] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/router_input_port_if.sv
// Flit ingress (credit-governed) and switch-side
// valid/ready handshake of a router input port.
interface router_input_port_if;
    import router_input_port_pkg::*;

    logic [FLIT_W-1:0] in_flit;
    logic              in_valid;
    logic              credit_out;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_port;

    modport master (
        output in_flit, in_valid, out_ready,
        input  credit_out, out_flit, out_valid, out_port
    );

    modport slave (
        input  in_flit, in_valid, out_ready,
        output credit_out, out_flit, out_valid, out_port
    );

endinterface

// File: rtl/router_input_port_flit_fifo.sv
// Circular flit buffer with occupancy count and
// sticky overflow flag for writes into a full buffer.
module router_input_port_flit_fifo
    import router_input_port_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [FLIT_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [FLIT_W-1:0] rdata_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              overflow_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full, do_push, do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full buffer still takes a write when a slot frees this cycle.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        ovf_d    = ovf_q || (push_i && full && !do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o    = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/router_input_port.sv
// Credit-based router input port: flit buffer, XY route
// computation on head flits and per-packet route hold.
module router_input_port
    import router_input_port_pkg::*;
#(
    parameter int X_ID  = 0,
    parameter int Y_ID  = 0,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    router_input_port_if.slave   bus,
    output logic [CNT_W-1:0]     fifo_count_o,
    output logic                 overflow_o,
    output logic                 framing_err_o
);
    state_e            state_q, state_d;
    logic [4:0]        route_q, route_d;
    logic              credit_q;
    logic              ferr_q, ferr_d;
    logic [FLIT_W-1:0] front;
    logic              empty, pop, out_valid;
    logic [4:0]        route_c;
    flit_type_e        ftype;

    router_input_port_flit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (bus.in_valid),
        .wdata_i    (bus.in_flit),
        .pop_i      (pop),
        .rdata_o    (front),
        .count_o    (fifo_count_o),
        .empty_o    (empty),
        .overflow_o (overflow_o)
    );

    assign ftype   = flit_type_e'(front[TYPE_HI:TYPE_LO]);
    assign route_c = xy_route(front[DX_HI:DX_LO], front[DY_HI:DY_LO],
                              2'(X_ID), 2'(Y_ID));

    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        ferr_d    = ferr_q;
        out_valid = 1'b0;
        pop       = 1'b0;
        if (!empty) begin
            unique case (state_q)
                ST_HEAD: begin
                    if (ftype == FT_HEAD || ftype == FT_SINGLE) begin
                        out_valid = 1'b1;
                        pop       = bus.out_ready;
                        if (pop && ftype == FT_HEAD) begin
                            state_d = ST_BODY;
                            route_d = route_c;
                        end
                    end else begin
                        // Orphan body/tail: drop it and hand the credit back.
                        pop    = 1'b1;
                        ferr_d = 1'b1;
                    end
                end
                ST_BODY: begin
                    out_valid = 1'b1;
                    pop       = bus.out_ready;
                    if (pop && ftype == FT_TAIL) state_d = ST_HEAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_HEAD;
            route_q  <= '0;
            credit_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            route_q  <= route_d;
            credit_q <= pop;
            ferr_q   <= ferr_d;
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_flit   = out_valid ? front : '0;
    assign bus.out_port   = !out_valid ? 5'b0 :
                            (state_q == ST_HEAD) ? route_c : route_q;
    assign bus.credit_out = credit_q;
    assign framing_err_o  = ferr_q;

endmodule

// File: tb/tb_router_input_port.sv
// Bench for router_input_port: packet-level model with
// per-cycle compare plus hand-computed directed checks.
module tb_router_input_port;
    localparam int XI = 1;
    localparam int YI = 1;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    router_input_port_if bus();
    logic [2:0] fifo_count;
    logic       overflow, framing_err;

    router_input_port #(.X_ID(XI), .Y_ID(YI), .DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .fifo_count_o  (fifo_count),
        .overflow_o    (overflow),
        .framing_err_o (framing_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] q[$];
    bit          exp_head = 1'b1;
    logic [4:0]  route_l = '0;
    bit          cred_e, ovf_e, ferr_e;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] mroute(input logic [19:0] f);
        int dx, dy;
        dx = int'(f[17:16]);
        dy = int'(f[15:14]);
        if (dx > XI) return 5'b01000;
        if (dx < XI) return 5'b10000;
        if (dy > YI) return 5'b00010;
        if (dy < YI) return 5'b00100;
        return 5'b00001;
    endfunction

    function automatic bit orphan(input logic [19:0] f);
        return f[19:18] == 2'b00 || f[19:18] == 2'b10;
    endfunction

    task automatic model_step();
        logic [19:0] f;
        bit pop, disc;
        pop  = 1'b0;
        disc = 1'b0;
        f    = '0;
        if (q.size() > 0) begin
            disc = exp_head && orphan(q[0]);
            pop  = disc || bus.out_ready;
        end
        cred_e = pop;
        if (pop) begin
            f = q.pop_front();
            if (disc) ferr_e = 1'b1;
            else if (exp_head && f[19:18] == 2'b01) begin
                exp_head = 1'b0;
                route_l  = mroute(f);
            end else if (!exp_head && f[19:18] == 2'b10)
                exp_head = 1'b1;
        end
        if (bus.in_valid) begin
            if (q.size() < D) q.push_back(bus.in_flit);
            else ovf_e = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            exp_head = 1'b1;
            route_l  = '0;
            cred_e   = 1'b0;
            ovf_e    = 1'b0;
            ferr_e   = 1'b0;
        end else model_step();
    end

    initial forever begin
        logic        ev;
        logic [19:0] ef;
        logic [4:0]  ep;
        @(negedge clk);
        if (!rst) begin
            ev = 1'b0;
            ef = '0;
            ep = '0;
            if (q.size() > 0 && !(exp_head && orphan(q[0]))) begin
                ev = 1'b1;
                ef = q[0];
                ep = exp_head ? mroute(q[0]) : route_l;
            end
            chk("m_valid", 32'(bus.out_valid), 32'(ev));
            chk("m_flit", 32'(bus.out_flit), 32'(ef));
            chk("m_port", 32'(bus.out_port), 32'(ep));
            chk("m_count", 32'(fifo_count), 32'(q.size()));
            chk("m_credit", 32'(bus.credit_out), 32'(cred_e));
            chk("m_ovf", 32'(overflow), 32'(ovf_e));
            chk("m_ferr", 32'(framing_err), 32'(ferr_e));
        end
    end

    task automatic tick(input logic v, input logic [19:0] f,
                        input logic r);
        bus.in_valid  = v;
        bus.in_flit   = f;
        bus.out_ready = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_flit"}, 32'(bus.out_flit), 0);
        chk({tag, "_port"}, 32'(bus.out_port), 0);
        chk({tag, "_count"}, 32'(fifo_count), 0);
        chk({tag, "_credit"}, 32'(bus.credit_out), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_ferr"}, 32'(framing_err), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_flit   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst0");
        #1 rst = 1'b0;

        // single flit to (2,1): east
        tick(1, 20'hE4000, 1);
        chk("t1_valid", 32'(bus.out_valid), 1);
        chk("t1_port", 32'(bus.out_port), 32'b01000);
        chk("t1_count", 32'(fifo_count), 1);
        tick(0, 0, 1);
        chk("t1_credit", 32'(bus.credit_out), 1);
        chk("t1_count0", 32'(fifo_count), 0);
        tick(0, 0, 0);
        chk("t1_credit0", 32'(bus.credit_out), 0);

        // 4-flit packet to (1,0): south, held then drained
        tick(1, 20'h50001, 0);
        tick(1, 20'h00002, 0);
        tick(1, 20'h00003, 0);
        tick(1, 20'h80004, 0);
        chk("t2_count", 32'(fifo_count), 4);
        chk("t2_port", 32'(bus.out_port), 32'b00100);
        chk("t2_flit", 32'(bus.out_flit), 32'h50001);
        tick(0, 0, 1);
        chk("t2_credit1", 32'(bus.credit_out), 1);
        chk("t2_port_body", 32'(bus.out_port), 32'b00100);
        chk("t2_flit_body", 32'(bus.out_flit), 32'h00002);
        tick(0, 0, 1);
        tick(0, 0, 1);
        tick(0, 0, 1);
        chk("t2_credit4", 32'(bus.credit_out), 1);
        chk("t2_count0", 32'(fifo_count), 0);
        tick(1, 20'hD8000, 1);
        chk("t2_next_head_port", 32'(bus.out_port), 32'b00010);
        tick(0, 0, 1);

        // overflow: full + pop accepts, full without pop drops
        do_reset();
        tick(1, 20'h44001, 0);
        tick(1, 20'h00002, 0);
        tick(1, 20'h00003, 0);
        tick(1, 20'h00004, 0);
        chk("t3_count_full", 32'(fifo_count), 4);
        chk("t3_port_w", 32'(bus.out_port), 32'b10000);
        tick(1, 20'h00005, 1);
        chk("t3_count_swap", 32'(fifo_count), 4);
        chk("t3_ovf0", 32'(overflow), 0);
        tick(1, 20'h80006, 0);
        chk("t3_count_drop", 32'(fifo_count), 4);
        chk("t3_ovf1", 32'(overflow), 1);
        repeat (4) tick(0, 0, 1);

        // orphan body flit while expecting a head
        do_reset();
        tick(1, 20'h00009, 0);
        chk("t4_valid", 32'(bus.out_valid), 0);
        chk("t4_count", 32'(fifo_count), 1);
        tick(0, 0, 0);
        chk("t4_count0", 32'(fifo_count), 0);
        chk("t4_ferr", 32'(framing_err), 1);
        chk("t4_credit", 32'(bus.credit_out), 1);

        // local delivery, then reset mid-packet
        tick(1, 20'hD4005, 1);
        chk("t5_port_l", 32'(bus.out_port), 32'b00001);
        tick(0, 0, 1);
        tick(1, 20'h68000, 0);
        tick(1, 20'h00001, 0);
        chk("t5_count2", 32'(fifo_count), 2);
        chk("t5_port_e", 32'(bus.out_port), 32'b01000);
        rst = 1'b1;
        #1;
        chk_reset_vals("t5_rst");
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        tick(1, 20'hE8000, 1);
        chk("t5_after_port", 32'(bus.out_port), 32'b01000);
        chk("t5_after_flit", 32'(bus.out_flit), 32'hE8000);
        tick(0, 0, 1);
        chk("t5_after_credit", 32'(bus.credit_out), 1);
        chk("t5_after_count", 32'(fifo_count), 0);
        tick(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
